// File: rtl/mips32_pkg.sv
// Shared types and defaults for the PC sequencer.
// States, reset/exception vectors and redirect causes.
package mips32_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Numeric order doubles as redirect priority.
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BRANCH = 2'd1,
        CAUSE_JUMP   = 2'd2,
        CAUSE_EXC    = 2'd3
    } cause_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/redirect_latch.sv
// Pending redirect register for the PC sequencer.
// Higher-priority causes overwrite lower ones; cleared on apply.
import mips32_pkg::*;

module redirect_latch #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              apply,
    input  cause_t            in_cause,
    input  logic [ADDR_W-1:0] in_target,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_target
);

    cause_t pend_cause;

    // Capture redirects while the PC is not advancing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_cause  <= CAUSE_NONE;
            pend_target <= '0;
        end else if (apply) begin
            pend_valid <= 1'b0;
            pend_cause <= CAUSE_NONE;
        end else if (in_cause != CAUSE_NONE && in_cause >= pend_cause) begin
            pend_valid  <= 1'b1;
            pend_cause  <= in_cause;
            pend_target <= in_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch FSM, next-PC mux,
// pc/epc registers and redirect arbitration.
import mips32_pkg::*;

module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exception,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] nextpc,
    output logic [ADDR_W-1:0] pc_cur,
    output logic              flush,
    output logic [ADDR_W-1:0] epc
);

    state_t            state, state_nx;
    cause_t            in_cause;
    logic [ADDR_W-1:0] in_target;
    logic              advance;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    // Pick the highest-priority redirect raised this cycle.
    always_comb begin
        in_cause  = CAUSE_NONE;
        in_target = '0;
        if (exception) begin
            in_cause  = CAUSE_EXC;
            in_target = {EXC_VECTOR[ADDR_W-1:2], 2'b00};
        end else if (jump) begin
            in_cause  = CAUSE_JUMP;
            in_target = {jump_target[ADDR_W-1:2], 2'b00};
        end else if (branch_taken) begin
            in_cause  = CAUSE_BRANCH;
            in_target = {branch_target[ADDR_W-1:2], 2'b00};
        end
    end

    redirect_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clock       (clock),
        .reset       (reset),
        .apply       (advance),
        .in_cause    (in_cause),
        .in_target   (in_target),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

    // Fetch state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nx;
    end

    // Next state, handshake outputs and next-PC selection.
    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        advance   = 1'b0;
        nextpc    = pc_cur + ADDR_W'(4);
        unique case (state)
            BOOT: begin
                state_nx = FETCH;
                nextpc   = pc_cur;
            end
            FETCH, WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    advance  = !stall;
                    state_nx = stall ? HOLD : FETCH;
                end else begin
                    state_nx = WAIT;
                end
            end
            HOLD: begin
                if (!stall) state_nx = FETCH;
            end
            default: state_nx = BOOT;
        endcase
        if (state != BOOT) begin
            if (in_cause != CAUSE_NONE) nextpc = in_target;
            else if (pend_valid)        nextpc = pend_target;
        end
    end

    assign pc_enable = advance;
    assign flush     = advance && (in_cause != CAUSE_NONE || pend_valid);

    // PC and exception-PC registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_cur <= RESET_VECTOR;
            epc    <= '0;
        end else begin
            if (advance)   pc_cur <= nextpc;
            if (exception) epc    <= pc_cur;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Directed scenarios plus random traffic against a behavioural model.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, jump, exception, imem_ready;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, pc_enable, flush;
    logic [31:0] nextpc, pc_cur, epc;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc_enable     (pc_enable),
        .nextpc        (nextpc),
        .pc_cur        (pc_cur),
        .flush         (flush),
        .epc           (epc)
    );

    always #5 clock = ~clock;

    wire [98:0] obsv = {imem_req, pc_enable, flush, nextpc, pc_cur, epc};
    logic [98:0] expv;

    // Behavioural model: booted/holding flags, pc, epc, one pending slot.
    bit          m_booted, m_hold, m_pv;
    int          m_pp;
    logic [31:0] m_pc, m_epc, m_pt;
    bit          m_s, m_r, m_e, m_adv;
    int          m_ip;
    logic [31:0] m_it, m_np;

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic m_reset();
        m_booted = 0; m_hold = 0; m_pv = 0; m_pp = 0;
        m_pt = 0; m_pc = 0; m_epc = 0;
        expv = {3'b000, 32'h0, 32'h0, 32'h0};
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt,
                        input bit e, input bit r);
        bit req;
        stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; exception = e; imem_ready = r;
        @(negedge clock);
        m_s = s; m_r = r; m_e = e;
        m_ip = e ? 3 : j ? 2 : b ? 1 : 0;
        m_it = e ? 32'h80 : j ? al(jt) : al(bt);
        req = m_booted && !m_hold;
        m_adv = req && r && !s;
        if (!m_booted)    m_np = m_pc;
        else if (m_ip > 0) m_np = m_it;
        else if (m_pv)     m_np = m_pt;
        else               m_np = m_pc + 32'd4;
        expv = {req, m_adv, m_adv && (m_ip > 0 || m_pv), m_np, m_pc, m_epc};
    endtask

    task automatic tick();
        @(posedge clock);
        if (!m_booted)         m_booted = 1;
        else if (m_hold)       m_hold = m_s;
        else if (m_r && m_s)   m_hold = 1;
        if (m_e) m_epc = m_pc;
        if (m_adv) begin
            m_pc = m_np;
            m_pv = 0;
            m_pp = 0;
        end else if (m_ip > 0 && (!m_pv || m_ip >= m_pp)) begin
            m_pv = 1;
            m_pp = m_ip;
            m_pt = m_it;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; stall = 0; branch_taken = 0; jump = 0;
        exception = 0; imem_ready = 0;
        branch_target = 0; jump_target = 0;
        m_reset();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; branch_taken = 0; jump = 0;
        exception = 0; imem_ready = 1;
        branch_target = 0; jump_target = 0;
        m_reset();
        #2;
        checks++;
        if (obsv !== expv) begin
            failures++;
            $display("FAIL reset got=%h want=%h", obsv, expv);
        end
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL seq c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
        end
        checks++;
        if (pc_cur !== 32'hC) begin
            failures++;
            $display("FAIL seq_pc got=%h want=%h", pc_cur, 32'hC);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(0, c == 3, 32'h0000_0103, 0, 0, 0, 1);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL branch c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
            if (c == 3) begin
                checks++;
                if (pc_cur !== 32'h100) begin
                    failures++;
                    $display("FAIL branch_pc got=%h want=%h", pc_cur, 32'h100);
                end
            end
        end
    endtask

    task automatic test_stall_jump();
        bit sv[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(sv[c], 0, 0, c == 3, 32'h200, 0, 1);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL stall c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
            if (c == 6) begin
                checks++;
                if (pc_cur !== 32'h200) begin
                    failures++;
                    $display("FAIL stall_pc got=%h want=%h", pc_cur, 32'h200);
                end
            end
        end
    endtask

    task automatic test_exc_priority();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(0, c == 2, 32'h500, c == 1 || c == 2,
                 c == 1 ? 32'h40 : 32'h300, c == 2, 1);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL exc c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
            if (c == 2) begin
                checks++;
                if (pc_cur !== 32'h80 || epc !== 32'h40) begin
                    failures++;
                    $display("FAIL exc_pc got=%h/%h want=80/40", pc_cur, epc);
                end
            end
        end
    endtask

    task automatic test_wait_wrap();
        bit rv[6] = '{1, 1, 0, 0, 1, 1};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, c == 1, 32'hFFFF_FFFE, 0, rv[c]);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL wait c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
            if (c == 4) begin
                checks++;
                if (pc_cur !== 32'h0) begin
                    failures++;
                    $display("FAIL wrap_pc got=%h want=%h", pc_cur, 32'h0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit rv[4] = '{1, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(0, c == 3, 32'h600, 0, 0, 0, rv[c]);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL midw c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
        end
        stall = 0; branch_taken = 0; imem_ready = 0;
        #2;
        reset = 1;
        m_reset();
        #1;
        checks++;
        if (obsv !== expv) begin
            failures++;
            $display("FAIL midw_rst got=%h want=%h", obsv, expv);
        end
        @(posedge clock);
        #1;
        reset = 0;
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL restart c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7);
            checks++;
            if (obsv !== expv) begin
                failures++;
                $display("FAIL rand c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_jump();
        test_exc_priority();
        test_wait_wrap();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
